line_xfer_arb: RTL
==================

# line_xfer_arb

Parametrised multi-channel cache-line transfer engine with round-robin arbitration. It serialises whole-line read (fill) and write (write-back) requests from `N_CH` cache-side requesters onto one beat-wide simulated-memory port, with configurable memory read latency. It replaces the single-channel line-to-beat path between the processor top and `mem_sim` in the test environment. An optional critical-word-first wrap mode is available.

## Interface
- `N_CH`, 2: number of requesting channels (1..8).
- `ADDR_WIDTH`, 64: byte address width.
- `BEAT_WIDTH`, 32: memory word width; power of two, ≥8.
- `LINE_WIDTH`, 512: cache line width; power-of-two multiple of `BEAT_WIDTH`. Derived `BEATS = LINE_WIDTH/BEAT_WIDTH`.
- `MEM_LATENCY`, 1: cycles from `o_addr_mem` to valid `i_data_mem` (0..4).
- `clk` in 1: single clock, rising edge.
- `arstn` in 1: asynchronous, active-low reset.
- `i_start_read` in N_CH: per-channel line-read request (level).
- `i_start_write` in N_CH: per-channel line-write request (level).
- `i_addr` in N_CH×ADDR_WIDTH: per-channel line byte address.
- `i_data_line` in N_CH×LINE_WIDTH: per-channel write line.
- `o_data_line` out LINE_WIDTH: last completed read line (shared).
- `o_read_last` out N_CH: one-cycle read-done pulse, one-hot.
- `o_b_resp` out N_CH: one-cycle write-done pulse, one-hot.
- `o_addr_mem` out ADDR_WIDTH: memory byte address.
- `o_data_mem` out BEAT_WIDTH: memory write data.
- `o_we_mem` out 1: memory write enable.
- `i_data_mem` in BEAT_WIDTH: memory read data.

## Operation
- States: IDLE, READ, WRITE, DONE.
- IDLE: a channel is pending if its read or write request is set. The round-robin arbiter picks the first pending channel at or after pointer `rr_ptr`. On a grant, latch channel, op, line base (`i_addr` with low log2(LINE_WIDTH/8) bits cleared) and `i_data_line`.
- Go to WRITE if the granted channel has `i_start_write` set; this applies even when its read is also set (write-back precedes fill). Otherwise go to READ.
- Advance `rr_ptr` to granted+1 mod `N_CH`.
- WRITE: one beat per cycle. `o_we_mem`=1, `o_addr_mem`=base+k·BEAT_WIDTH/8, `o_data_mem`=line[k·BEAT_WIDTH +: BEAT_WIDTH], for k=0..BEATS-1. Go to DONE after beat BEATS-1.
- READ: issue counter drives addresses for beats 0..BEATS-1 on consecutive cycles, then holds the last address. A receive counter captures `i_data_mem` into line slot k `MEM_LATENCY` cycles after address k. `o_we_mem`=0. Go to DONE when beat BEATS-1 is captured.
- DONE: pulse `o_read_last[ch]` or `o_b_resp[ch]` for one cycle. After a read, `o_data_line` updates to the assembled line in DONE and holds until the next read completes. Return to IDLE.
- The requester must drop the served request by the cycle after the pulse. A still-held request is treated as a new request.
- Requests changing mid-transfer are ignored; only the latched values are used.
- Unaligned address without wrap: offset bits are ignored.

## Timing
- Grant in IDLE cycle T0.
- Write: beats on T1..T_BEATS; `o_b_resp` at T_BEATS+1.
- Read: addresses on T1..T_BEATS; `o_read_last` at T_BEATS+MEM_LATENCY+1. With defaults: write pulse at T17, read pulse at T18.
- IDLE lasts one cycle between transfers. Back-to-back grant cadence is BEATS+2 (write) or BEATS+MEM_LATENCY+2 (read) cycles.
- All outputs are registered.
- Reset values: `o_data_line`, `o_read_last`, `o_b_resp`, `o_addr_mem`, `o_data_mem`, `o_we_mem` all 0. State is IDLE and `rr_ptr`=0.
- Reset mid-transfer aborts immediately with no pulse. A partial line is never exposed on `o_data_line`. Memory may hold partially written beats.
- With no request pending, stay in IDLE with `o_we_mem`=0.

## Configuration
- `LINE_XFER_WRAP_EN` defined: critical-word-first. The start beat is s = address offset / (BEAT_WIDTH/8). Beats are issued in order s, s+1, …, BEATS-1, 0, …, s-1, for both reads and writes.
- Each beat still maps to its natural slot in the line, so the assembled line equals the aligned result.
- Latency is unchanged.
- `LINE_XFER_WRAP_EN` undefined: beat order is always 0..BEATS-1 and offset bits are ignored.

## Structure
- `line_xfer_pkg`: state enum `xfer_state_t`, op enum `xfer_op_t` (READ/WRITE), and function `beats_f(LINE_WIDTH, BEAT_WIDTH)`.
- Sub-module `rr_arbiter`: parameter `N_CH`; inputs are the pending vector and `rr_ptr`; outputs are a grant index and a valid flag. It is combinational, and the pointer register lives in the parent.

## Test plan
- Read ch0 @0x1000, memory word = its address: `o_addr_mem` 0x1000..0x103C on T1..T16; `o_read_last`=01 at T18; `o_data_line[32i+:32]`=0x1000+4i.
- Write ch1 @0x2040, beat i=0xA0000000+i: `o_we_mem` high on T1..T16; `o_b_resp`=10 at T17; a later read returns the identical line.
- Both channels hold reads continuously from reset: grants go ch0, ch1, ch0, ch1; no pulse appears on the non-granted channel.
- ch0 asserts read+write @0x3000 together: write served first, then read; the read line equals the written line.
- `arstn` low during READ beat 7: all outputs 0 the same cycle, no pulse; a fresh read after release completes normally.
- `LINE_XFER_WRAP_EN`, read @0x1028: addresses 0x1028..0x103C then 0x1000..0x1024; line equals the aligned read of 0x1000.

Source files
------------

// File: rtl/line_xfer_pkg.sv
// Shared types and helpers for the line_xfer_arb transfer engine.
package line_xfer_pkg;

   typedef enum logic [1:0] {
      S_IDLE,
      S_READ,
      S_WRITE,
      S_DONE
   } xfer_state_t;

   typedef enum logic {
      OP_READ,
      OP_WRITE
   } xfer_op_t;

   function automatic int beats_f(input int line_width, input int beat_width);
      return line_width / beat_width;
   endfunction

endpackage

// File: rtl/line_xfer_arb_rr.sv
// Combinational round-robin arbiter: grants the first pending channel at or
// after rr_ptr. The pointer register is owned by the parent.
module rr_arbiter #(
   parameter int N_CH = 2,
   localparam int PW = (N_CH > 1) ? $clog2(N_CH) : 1
) (
   input  logic [N_CH-1:0] pending,
   input  logic [PW-1:0]   rr_ptr,
   output logic [PW-1:0]   grant,
   output logic            valid
);

   int idx;

   // Walk offsets from farthest to nearest so the nearest pending channel wins.
   always_comb begin
      grant = '0;
      valid = 1'b0;
      idx   = 0;
      for (int i = N_CH - 1; i >= 0; i--) begin
         idx = (int'(rr_ptr) + i) % N_CH;
         if (pending[idx]) begin
            grant = PW'(idx);
            valid = 1'b1;
         end
      end
   end

endmodule

// File: rtl/line_xfer_arb.sv
// Multi-channel cache-line transfer engine with round-robin arbitration.
// Define LINE_XFER_WRAP_EN for critical-word-first beat ordering.
module line_xfer_arb
   import line_xfer_pkg::*;
#(
   parameter int N_CH        = 2,
   parameter int ADDR_WIDTH  = 64,
   parameter int BEAT_WIDTH  = 32,
   parameter int LINE_WIDTH  = 512,
   parameter int MEM_LATENCY = 1
) (
   input  logic                                 clk,
   input  logic                                 arstn,
   input  logic [N_CH-1:0]                      i_start_read,
   input  logic [N_CH-1:0]                      i_start_write,
   input  logic [N_CH-1:0][ADDR_WIDTH-1:0]      i_addr,
   input  logic [N_CH-1:0][LINE_WIDTH-1:0]      i_data_line,
   output logic [LINE_WIDTH-1:0]                o_data_line,
   output logic [N_CH-1:0]                      o_read_last,
   output logic [N_CH-1:0]                      o_b_resp,
   output logic [ADDR_WIDTH-1:0]                o_addr_mem,
   output logic [BEAT_WIDTH-1:0]                o_data_mem,
   output logic                                 o_we_mem,
   input  logic [BEAT_WIDTH-1:0]                i_data_mem
);

   localparam int BEATS      = beats_f(LINE_WIDTH, BEAT_WIDTH);
   localparam int BEAT_BYTES = BEAT_WIDTH / 8;
   localparam int LINE_BYTES = LINE_WIDTH / 8;
   localparam int IW         = (BEATS > 1) ? $clog2(BEATS) : 1;
   localparam int PW         = (N_CH > 1) ? $clog2(N_CH) : 1;
   localparam int CW         = $clog2(BEATS + MEM_LATENCY + 2) + 1;
   localparam logic [ADDR_WIDTH-1:0] LINE_MASK = ADDR_WIDTH'(LINE_BYTES - 1);

   xfer_state_t             state_reg;
   xfer_op_t                op_reg;
   logic [PW-1:0]           ch_reg;
   logic [PW-1:0]           rr_ptr_reg;
   logic [ADDR_WIDTH-1:0]   base_reg;
   logic [IW-1:0]           start_reg;
   logic [CW-1:0]           cyc_reg;
   logic [LINE_WIDTH-1:0]   line_buf_reg;

   logic [N_CH-1:0]         pending;
   logic [PW-1:0]           g_idx;
   logic                    g_valid;
   logic [ADDR_WIDTH-1:0]   g_addr;
   logic [ADDR_WIDTH-1:0]   g_base;
   logic [IW-1:0]           g_start;
   logic [LINE_WIDTH-1:0]   g_line;
   logic [IW-1:0]           issue_slot;
   logic [CW-1:0]           rx_idx;
   logic [IW-1:0]           rx_slot;
   logic [LINE_WIDTH-1:0]   line_cap;

   // Beat j of a transfer lands in slot (start + j) mod BEATS; start is 0 unless wrapping.
   function automatic logic [IW-1:0] order_f(input logic [IW-1:0] s, input logic [CW-1:0] j);
      return IW'((int'(s) + int'(j)) % BEATS);
   endfunction

   assign pending = i_start_read | i_start_write;

   rr_arbiter #(.N_CH(N_CH)) u_arb (
      .pending (pending),
      .rr_ptr  (rr_ptr_reg),
      .grant   (g_idx),
      .valid   (g_valid)
   );

`ifdef LINE_XFER_WRAP_EN
   logic [ADDR_WIDTH-1:0] g_word;
`endif

   always_comb begin
      g_addr = i_addr[g_idx];
      g_line = i_data_line[g_idx];
      g_base = g_addr & ~LINE_MASK;
`ifdef LINE_XFER_WRAP_EN
      g_word  = g_addr >> $clog2(BEAT_BYTES);
      g_start = IW'(g_word & ADDR_WIDTH'(BEATS - 1));
`else
      g_start = '0;
`endif
      issue_slot = order_f(start_reg, cyc_reg);
      rx_idx     = cyc_reg - CW'(MEM_LATENCY + 1);
      rx_slot    = order_f(start_reg, rx_idx);
      line_cap   = line_buf_reg;
      line_cap[int'(rx_slot)*BEAT_WIDTH +: BEAT_WIDTH] = i_data_mem;
   end

   always_ff @(posedge clk or negedge arstn) begin
      if (!arstn) begin
         state_reg    <= S_IDLE;
         op_reg       <= OP_READ;
         ch_reg       <= '0;
         rr_ptr_reg   <= '0;
         base_reg     <= '0;
         start_reg    <= '0;
         cyc_reg      <= '0;
         line_buf_reg <= '0;
         o_data_line  <= '0;
         o_read_last  <= '0;
         o_b_resp     <= '0;
         o_addr_mem   <= '0;
         o_data_mem   <= '0;
         o_we_mem     <= 1'b0;
      end else begin
         o_read_last <= '0;
         o_b_resp    <= '0;
         case (state_reg)
            S_IDLE: begin
               o_we_mem <= 1'b0;
               if (g_valid) begin
                  ch_reg       <= g_idx;
                  base_reg     <= g_base;
                  start_reg    <= g_start;
                  line_buf_reg <= g_line;
                  cyc_reg      <= CW'(1);
                  rr_ptr_reg   <= (int'(g_idx) == N_CH - 1) ? '0 : g_idx + PW'(1);
                  o_addr_mem   <= g_base + ADDR_WIDTH'(int'(g_start) * BEAT_BYTES);
                  // Write-back wins over fill when both are requested.
                  if (i_start_write[g_idx]) begin
                     op_reg     <= OP_WRITE;
                     state_reg  <= S_WRITE;
                     o_we_mem   <= 1'b1;
                     o_data_mem <= g_line[int'(g_start)*BEAT_WIDTH +: BEAT_WIDTH];
                  end else begin
                     op_reg    <= OP_READ;
                     state_reg <= S_READ;
                  end
               end
            end
            S_READ, S_WRITE: begin
               cyc_reg <= cyc_reg + CW'(1);
               if (int'(cyc_reg) < BEATS) begin
                  o_addr_mem <= base_reg + ADDR_WIDTH'(int'(issue_slot) * BEAT_BYTES);
                  if (op_reg == OP_WRITE)
                     o_data_mem <= line_buf_reg[int'(issue_slot)*BEAT_WIDTH +: BEAT_WIDTH];
               end
               if (op_reg == OP_WRITE) begin
                  if (int'(cyc_reg) >= BEATS) begin
                     o_we_mem         <= 1'b0;
                     o_b_resp[ch_reg] <= 1'b1;
                     state_reg        <= S_DONE;
                  end
               end else if (int'(cyc_reg) >= MEM_LATENCY + 1) begin
                  line_buf_reg <= line_cap;
                  // Only a complete line is ever published.
                  if (int'(rx_idx) == BEATS - 1) begin
                     o_data_line         <= line_cap;
                     o_read_last[ch_reg] <= 1'b1;
                     state_reg           <= S_DONE;
                  end
               end
            end
            S_DONE: begin
               state_reg <= S_IDLE;
            end
            default: begin
               state_reg <= S_IDLE;
            end
         endcase
      end
   end

endmodule
